// File: rtl/mole_game_core.sv
// Whack-a-mole engine: LFSR hole pick, level-scaled show/gap windows,
// hit/miss scoring of debounced key presses, and win/loss end states.
module mole_game_core #(
  parameter int N_HOLES        = 4,
  parameter int HOLE_BITS      = 2,
  parameter int LEVELS         = 4,
  parameter int HITS_PER_LEVEL = 5,
  parameter int MAX_MISSES     = 3,
  parameter int BASE_LOG2      = 27,
  parameter int SCORE_W        = 8
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iSTART,
  input  logic [N_HOLES-1:0] iKEY_N,
  output logic [N_HOLES-1:0] oMOLE,
  output logic [SCORE_W-1:0] oHITS,
  output logic [3:0]         oMISSES,
  output logic [2:0]         oLEVEL,
  output logic [2:0]         oSTATE,
  output logic               oHIT_P,
  output logic               oMISS_P
);
  localparam int                 TW          = BASE_LOG2 + 1;
  localparam logic [TW-1:0]      T_ONE       = TW'(1);
  localparam logic [5:0]         BASE_SH     = 6'(BASE_LOG2);
  localparam logic [SCORE_W-1:0] WIN_HITS    = SCORE_W'(LEVELS * HITS_PER_LEVEL);
  localparam logic [3:0]         LOSS_MISSES = 4'(MAX_MISSES);
  localparam logic [15:0]        LFSR_SEED   = 16'hACE1;
  localparam logic [N_HOLES-1:0] HOLE_ONE    = N_HOLES'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SHOW = 3'd1,
    S_GAP  = 3'd2,
    S_LOST = 3'd3,
    S_WON  = 3'd4
  } state_e;

  function automatic logic [TW-1:0] window_len(input logic [2:0] lvl);
    return T_ONE << (BASE_SH - {3'b000, lvl});
  endfunction

  state_e             state_q, state_d;
  logic [N_HOLES-1:0] mole_q, mole_d;
  logic [SCORE_W-1:0] hits_q, hits_d;
  logic [3:0]         misses_q, misses_d;
  logic [2:0]         level_q, level_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               hit_p_q, hit_p_d;
  logic               miss_p_q, miss_p_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [N_HOLES-1:0] key_q;

  logic [HOLE_BITS-1:0] raw_s, idx_s;
  logic [N_HOLES-1:0]   pick_s, press_s;
  logic                 any_press_s, expire_s;
  logic [SCORE_W-1:0]   hit_cnt_s, lvl_target_s;
  logic [3:0]           miss_cnt_s;

  assign lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign pick_s       = HOLE_ONE << idx_s;
  assign press_s      = key_q & ~iKEY_N;
  assign any_press_s  = |press_s;
  assign expire_s     = (timer_q == T_ONE);
  assign hit_cnt_s    = hits_q + SCORE_W'(1);
  assign miss_cnt_s   = misses_q + 4'd1;
  assign lvl_target_s = SCORE_W'((32'(level_q) + 32'd1) * 32'(HITS_PER_LEVEL));

  // Fold the raw LFSR bits into a valid hole index
  always_comb begin
    raw_s = lfsr_q[HOLE_BITS-1:0];
    if (32'(raw_s) < N_HOLES) begin
      idx_s = raw_s;
    end else begin
      idx_s = raw_s - HOLE_BITS'(N_HOLES);
    end
  end

  // Game state register, LFSR and key history
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q  <= S_IDLE;
      mole_q   <= '0;
      hits_q   <= '0;
      misses_q <= 4'd0;
      level_q  <= 3'd0;
      timer_q  <= '0;
      hit_p_q  <= 1'b0;
      miss_p_q <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      key_q    <= '1;
    end else begin
      state_q  <= state_d;
      mole_q   <= mole_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      level_q  <= level_d;
      timer_q  <= timer_d;
      hit_p_q  <= hit_p_d;
      miss_p_q <= miss_p_d;
      lfsr_q   <= lfsr_d;
      key_q    <= iKEY_N;
    end
  end

  // Next-state logic: start beats presses, presses beat window expiry
  always_comb begin
    state_d  = state_q;
    mole_d   = mole_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    level_d  = level_q;
    timer_d  = timer_q;
    hit_p_d  = 1'b0;
    miss_p_d = 1'b0;
    if (iSTART) begin
      hits_d   = '0;
      misses_d = 4'd0;
      level_d  = 3'd0;
      mole_d   = pick_s;
      state_d  = S_SHOW;
      timer_d  = window_len(3'd0);
    end else begin
      case (state_q)
        S_SHOW: begin
          if (any_press_s && (press_s == mole_q)) begin
            hits_d  = hit_cnt_s;
            hit_p_d = 1'b1;
            mole_d  = '0;
            if (hit_cnt_s == WIN_HITS) begin
              state_d = S_WON;
            end else begin
              if (hit_cnt_s == lvl_target_s) begin
                level_d = level_q + 3'd1;
              end else begin
                level_d = level_q;
              end
              state_d = S_GAP;
              timer_d = window_len(level_d);
            end
          end else if (any_press_s || expire_s) begin
            misses_d = miss_cnt_s;
            miss_p_d = 1'b1;
            mole_d   = '0;
            if (miss_cnt_s == LOSS_MISSES) begin
              state_d = S_LOST;
            end else begin
              state_d = S_GAP;
              timer_d = window_len(level_q);
            end
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
        S_GAP: begin
          if (any_press_s) begin
            misses_d = miss_cnt_s;
            miss_p_d = 1'b1;
          end else begin
            misses_d = misses_q;
          end
          if (any_press_s && (miss_cnt_s == LOSS_MISSES)) begin
            state_d = S_LOST;
            mole_d  = '0;
          end else if (expire_s) begin
            state_d = S_SHOW;
            mole_d  = pick_s;
            timer_d = window_len(level_q);
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign oMOLE   = mole_q;
  assign oHITS   = hits_q;
  assign oMISSES = misses_q;
  assign oLEVEL  = level_q;
  assign oSTATE  = state_q;
  assign oHIT_P  = hit_p_q;
  assign oMISS_P = miss_p_q;
endmodule

// File: tb/tb_mole_game_core.sv
// Bench for mole_game_core: directed scenario tasks plus a randomized run,
// all checked against a game-level reference model.
module tb_mole_game_core;
  localparam int N = 4, LV = 2, HPL = 2, MAXM = 3, BL = 4, SW = 8;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [3:0]    keys;
  logic [3:0]    oMOLE;
  logic [SW-1:0] oHITS;
  logic [3:0]    oMISSES;
  logic [2:0]    oLEVEL, oSTATE;
  logic          oHIT_P, oMISS_P;

  always #5 clk = ~clk;

  mole_game_core #(
    .N_HOLES(N), .HOLE_BITS(2), .LEVELS(LV), .HITS_PER_LEVEL(HPL),
    .MAX_MISSES(MAXM), .BASE_LOG2(BL), .SCORE_W(SW)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iKEY_N(keys),
    .oMOLE(oMOLE), .oHITS(oHITS), .oMISSES(oMISSES), .oLEVEL(oLEVEL),
    .oSTATE(oSTATE), .oHIT_P(oHIT_P), .oMISS_P(oMISS_P)
  );

  int n_checks = 0, n_pass = 0;

  // Reference model: game-level view (0 idle, 1 show, 2 gap, 3 lost, 4 won)
  int       m_state = 0, m_hits = 0, m_misses = 0, m_level = 0, m_elapsed = 0;
  int       m_lfsr = 16'hACE1;
  logic [3:0] m_mole = 4'h0, m_key = 4'hF;
  logic     m_hit_p = 1'b0, m_miss_p = 1'b0;

  function automatic int win_len(int lvl);
    return 1 << (BL - lvl);
  endfunction

  function automatic logic [3:0] hole_mask(int l);
    int r;
    r = l & 3;
    if (r >= N) r = r - N;
    return 4'(1 << r);
  endfunction

  task automatic model_edge();
    logic [3:0] press;
    int fb;
    if (!rst_n) begin
      m_state = 0; m_hits = 0; m_misses = 0; m_level = 0; m_elapsed = 0;
      m_mole = 4'h0; m_hit_p = 1'b0; m_miss_p = 1'b0; m_key = 4'hF; m_lfsr = 16'hACE1;
      return;
    end
    press = m_key & ~keys;
    m_hit_p = 1'b0; m_miss_p = 1'b0;
    if (start) begin
      m_hits = 0; m_misses = 0; m_level = 0; m_elapsed = 0;
      m_mole = hole_mask(m_lfsr); m_state = 1;
    end else if (m_state == 1) begin
      if (press != 4'h0 && press == m_mole) begin
        m_hits++; m_hit_p = 1'b1; m_mole = 4'h0;
        if (m_hits == LV * HPL) m_state = 4;
        else begin
          if (m_hits == (m_level + 1) * HPL) m_level++;
          m_state = 2; m_elapsed = 0;
        end
      end else if (press != 4'h0 || m_elapsed + 1 == win_len(m_level)) begin
        m_misses++; m_miss_p = 1'b1; m_mole = 4'h0; m_elapsed = 0;
        m_state = (m_misses == MAXM) ? 3 : 2;
      end else m_elapsed++;
    end else if (m_state == 2) begin
      if (m_elapsed + 1 == win_len(m_level)) begin
        m_state = 1; m_mole = hole_mask(m_lfsr); m_elapsed = 0;
      end else m_elapsed++;
      if (press != 4'h0) begin
        m_misses++; m_miss_p = 1'b1;
        if (m_misses == MAXM) begin m_state = 3; m_mole = 4'h0; end
      end
    end
    m_key = keys;
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic press_once(input logic [3:0] mask);
    keys = ~mask;
    step();
    keys = 4'hF;
  endtask

  task automatic wait_show();
    for (int i = 0; i < 100 && m_state != 1; i++) step();
    n_checks++; if (oSTATE !== 3'd1) $display("FAIL wait_show: got state %0d expected 1", oSTATE); else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; keys = 4'hF;
    step(); step();
    n_checks++; if (oSTATE !== 3'd0) $display("FAIL reset_state: got %0d expected 0", oSTATE); else n_pass++;
    n_checks++; if (oMOLE !== 4'h0) $display("FAIL reset_mole: got %h expected 0", oMOLE); else n_pass++;
    n_checks++; if ({oHITS, oMISSES, oLEVEL} !== 15'd0) $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", oHITS, oMISSES, oLEVEL); else n_pass++;
    n_checks++; if ({oHIT_P, oMISS_P} !== 2'b00) $display("FAIL reset_strobes: got %b expected 00", {oHIT_P, oMISS_P}); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_timeout();
    int cnt, gap;
    start = 1'b1; step(); start = 1'b0;
    n_checks++; if (oSTATE !== 3'd1) $display("FAIL start_state: got %0d expected 1", oSTATE); else n_pass++;
    n_checks++; if (!$onehot(oMOLE) || oMOLE !== m_mole) $display("FAIL start_mole: got %h expected %h", oMOLE, m_mole); else n_pass++;
    cnt = 1;
    for (int i = 0; i < 40 && oMOLE != 4'h0; i++) begin
      step();
      if (oMOLE != 4'h0) cnt++;
    end
    n_checks++; if (cnt !== 16) $display("FAIL show_len0: got %0d expected 16", cnt); else n_pass++;
    n_checks++; if (oMISSES !== 4'd1 || oMISS_P !== 1'b1 || oSTATE !== 3'd2) $display("FAIL timeout_miss: got misses %0d pulse %b state %0d expected 1 1 2", oMISSES, oMISS_P, oSTATE); else n_pass++;
    step();
    n_checks++; if (oMISS_P !== 1'b0) $display("FAIL miss_pulse_width: got %b expected 0", oMISS_P); else n_pass++;
    gap = 2;
    for (int i = 0; i < 40 && oSTATE == 3'd2; i++) begin
      step();
      if (oSTATE == 3'd2) gap++;
    end
    n_checks++; if (gap !== 16) $display("FAIL gap_len0: got %0d expected 16", gap); else n_pass++;
    n_checks++; if (oSTATE !== 3'd1 || oMOLE !== m_mole) $display("FAIL new_hole: got state %0d mole %h expected 1 %h", oSTATE, oMOLE, m_mole); else n_pass++;
  endtask

  task automatic test_hit();
    press_once(m_mole);
    n_checks++; if (oHITS !== 8'd1 || oHIT_P !== 1'b1) $display("FAIL hit_count: got hits %0d pulse %b expected 1 1", oHITS, oHIT_P); else n_pass++;
    n_checks++; if (oMOLE !== 4'h0 || oSTATE !== 3'd2) $display("FAIL hit_to_gap: got mole %h state %0d expected 0 2", oMOLE, oSTATE); else n_pass++;
    step();
    n_checks++; if (oHIT_P !== 1'b0) $display("FAIL hit_pulse_width: got %b expected 0", oHIT_P); else n_pass++;
  endtask

  task automatic test_level_up();
    int cnt;
    wait_show();
    press_once(m_mole);
    n_checks++; if (oHITS !== 8'd2 || oLEVEL !== 3'd1) $display("FAIL level_up: got hits %0d level %0d expected 2 1", oHITS, oLEVEL); else n_pass++;
    wait_show();
    cnt = 1;
    for (int i = 0; i < 40 && oMOLE != 4'h0; i++) begin
      step();
      if (oMOLE != 4'h0) cnt++;
    end
    n_checks++; if (cnt !== 8) $display("FAIL show_len1: got %0d expected 8", cnt); else n_pass++;
    n_checks++; if (oMISSES !== 4'd2) $display("FAIL level1_timeout: got %0d expected 2", oMISSES); else n_pass++;
  endtask

  task automatic test_win();
    int strobes;
    wait_show(); press_once(m_mole);
    wait_show(); press_once(m_mole);
    n_checks++; if (oSTATE !== 3'd4 || oHITS !== 8'd4) $display("FAIL win: got state %0d hits %0d expected 4 4", oSTATE, oHITS); else n_pass++;
    n_checks++; if (oLEVEL !== 3'd1 || oMOLE !== 4'h0) $display("FAIL win_hold: got level %0d mole %h expected 1 0", oLEVEL, oMOLE); else n_pass++;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      press_once(4'(1 << i));
      if (oHIT_P || oMISS_P) strobes++;
      step();
    end
    n_checks++; if (strobes !== 0) $display("FAIL won_strobes: got %0d expected 0", strobes); else n_pass++;
    n_checks++; if (oHITS !== 8'd4 || oMISSES !== 4'd2 || oSTATE !== 3'd4) $display("FAIL won_frozen: got %0d/%0d state %0d expected 4/2 4", oHITS, oMISSES, oSTATE); else n_pass++;
  endtask

  task automatic test_loss();
    start = 1'b1; step(); start = 1'b0;
    n_checks++; if ({oHITS, oMISSES, oLEVEL} !== 15'd0 || oSTATE !== 3'd1) $display("FAIL restart_from_won: got %0d/%0d/%0d state %0d expected 0/0/0 1", oHITS, oMISSES, oLEVEL, oSTATE); else n_pass++;
    press_once({m_mole[2:0], m_mole[3]});
    n_checks++; if (oMISSES !== 4'd1 || oMISS_P !== 1'b1 || oHITS !== 8'd0 || oSTATE !== 3'd2) $display("FAIL wrong_key: got misses %0d pulse %b hits %0d state %0d expected 1 1 0 2", oMISSES, oMISS_P, oHITS, oSTATE); else n_pass++;
    step();
    press_once(4'h1);
    n_checks++; if (oMISSES !== 4'd2 || oSTATE !== 3'd2) $display("FAIL gap_press: got misses %0d state %0d expected 2 2", oMISSES, oSTATE); else n_pass++;
    wait_show();
    for (int i = 0; i < 40 && m_state == 1; i++) step();
    n_checks++; if (oMISSES !== 4'd3 || oSTATE !== 3'd3 || oMOLE !== 4'h0) $display("FAIL loss: got misses %0d state %0d mole %h expected 3 3 0", oMISSES, oSTATE, oMOLE); else n_pass++;
    press_once(4'hF);
    n_checks++; if (oMISS_P !== 1'b0 || oMISSES !== 4'd3) $display("FAIL lost_frozen: got pulse %b misses %0d expected 0 3", oMISS_P, oMISSES); else n_pass++;
  endtask

  task automatic test_multi_press();
    start = 1'b1; step(); start = 1'b0;
    press_once(m_mole | {m_mole[2:0], m_mole[3]});
    n_checks++; if (oMISSES !== 4'd1 || oHITS !== 8'd0) $display("FAIL multi_count: got misses %0d hits %0d expected 1 0", oMISSES, oHITS); else n_pass++;
    n_checks++; if (oMISS_P !== 1'b1 || oHIT_P !== 1'b0) $display("FAIL multi_strobe: got miss %b hit %b expected 1 0", oMISS_P, oHIT_P); else n_pass++;
  endtask

  task automatic test_restart();
    start = 1'b1; step(); start = 1'b0;
    for (int h = 0; h < 3; h++) begin
      wait_show();
      press_once(m_mole);
    end
    n_checks++; if (oHITS !== 8'd3 || oLEVEL !== 3'd1) $display("FAIL pre_restart: got hits %0d level %0d expected 3 1", oHITS, oLEVEL); else n_pass++;
    wait_show();
    start = 1'b1; keys = ~m_mole; step(); start = 1'b0; keys = 4'hF;
    n_checks++; if ({oHITS, oMISSES, oLEVEL} !== 15'd0 || oSTATE !== 3'd1 || oHIT_P !== 1'b0) $display("FAIL midgame_restart: got %0d/%0d/%0d state %0d hit %b expected 0/0/0 1 0", oHITS, oMISSES, oLEVEL, oSTATE, oHIT_P); else n_pass++;
    step(); step(); step();
    rst_n = 1'b0; step();
    n_checks++; if ({oSTATE, oMOLE, oHITS, oMISSES, oLEVEL, oHIT_P, oMISS_P} !== 24'd0) $display("FAIL midgame_reset: got state %0d mole %h hits %0d misses %0d level %0d", oSTATE, oMOLE, oHITS, oMISSES, oLEVEL); else n_pass++;
    rst_n = 1'b1; step();
  endtask

  task automatic test_random();
    logic [23:0] got, exp;
    int nf, r;
    nf = 0;
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (m_state == 0 || m_state >= 3) start = ($urandom_range(0, 9) == 0);
      else start = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 9);
      if (r == 0) keys = 4'($urandom);
      else if (r <= 2 && m_mole != 4'h0) keys = ~m_mole;
      else keys = 4'hF;
      step();
      got = {oSTATE, oMOLE, oHITS, oMISSES, oLEVEL, oHIT_P, oMISS_P};
      exp = {3'(m_state), m_mole, 8'(m_hits), 4'(m_misses), 3'(m_level), m_hit_p, m_miss_p};
      n_checks++;
      if (got !== exp) begin
        if (nf < 10) $display("FAIL random_cycle %0d: got %h expected %h", i, got, exp);
        nf++;
      end else n_pass++;
    end
    rst_n = 1'b1; start = 1'b0; keys = 4'hF;
    step();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; keys = 4'hF;
    test_reset();
    test_timeout();
    test_hit();
    test_level_up();
    test_win();
    test_loss();
    test_multi_press();
    test_restart();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
